// File: rtl/fprint_scan_pkg.sv
// rtl/fprint_scan_pkg.sv - shared state encoding and CRC-32 constants for the scratchpad scanner
package fprint_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } scan_state_e;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/fprint_crc32_step.sv
// rtl/fprint_crc32_step.sv - combinational fold of one 32-bit word into an MSB-first CRC-32
module fprint_crc32_step #(
    parameter logic [31:0] POLY = 32'h04C11DB7
) (
    input  logic [31:0] i_crc,
    input  logic [31:0] i_data,
    output logic [31:0] o_crc
);

    always_comb begin
        logic [31:0] w_x;
        w_x = i_crc ^ i_data;
        for (int i = 0; i < 32; i++) begin
            w_x = w_x[31] ? ((w_x << 1) ^ POLY) : (w_x << 1);
        end
        o_crc = w_x;
    end

endmodule

// File: rtl/fprint_scratchpad_crc_scanner.sv
// rtl/fprint_scratchpad_crc_scanner.sv - read master streaming a scratchpad word range into a CRC-32 fingerprint
module fprint_scratchpad_crc_scanner
    import fprint_scan_pkg::*;
#(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] POLY     = fprint_scan_pkg::CRC_POLY,
    parameter logic [31:0] CRC_INIT = fprint_scan_pkg::CRC_INIT
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_word_count,
    input  logic              i_hold,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [31:0]       o_crc_out,
    output logic [ADDR_W-1:0] o_sp_address,
    output logic              o_sp_chipselect,
    output logic              o_sp_write,
    output logic [3:0]        o_sp_byteenable,
    output logic              o_sp_clken,
    input  logic [31:0]       i_sp_readdata
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    scan_state_e       r_state;
    scan_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_cnt;
    logic              r_rd_valid;
    logic [31:0]       r_crc;
    logic [31:0]       r_crc_out;
    logic              r_err;

    logic              w_issue;
    logic              w_fold;
    logic              w_accept;
    logic              w_abort;
    logic              w_cnt_bad;
    logic              w_cnt_zero;
    logic [31:0]       w_crc_step;
    logic [31:0]       w_crc_next;

    assign w_issue    = (r_state == S_ISSUE) && !i_hold;
    assign w_fold     = r_rd_valid && !i_hold;
    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_abort    = (r_state != S_IDLE) && i_abort;
    assign w_cnt_bad  = i_word_count > DEPTH;
    assign w_cnt_zero = i_word_count == '0;
    assign w_crc_next = w_fold ? w_crc_step : r_crc;

    fprint_crc32_step #(
        .POLY (POLY)
    ) u_crc_step (
        .i_crc  (r_crc),
        .i_data (i_sp_readdata),
        .o_crc  (w_crc_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = (w_cnt_zero || w_cnt_bad) ? S_DONE : S_ISSUE;
            S_ISSUE: if (w_issue && r_cnt == {{ADDR_W{1'b0}}, 1'b1}) w_state_nxt = S_DRAIN;
            S_DRAIN: if (!i_hold) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_crc      <= CRC_INIT;
            r_crc_out  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr     <= i_base_addr;
                r_cnt      <= i_word_count;
                r_crc      <= CRC_INIT;
                r_err      <= w_cnt_bad;
                r_rd_valid <= 1'b0;
                if (w_cnt_zero || w_cnt_bad) r_crc_out <= CRC_INIT;
            end else if (w_abort) begin
                r_rd_valid <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_cnt  <= r_cnt - (ADDR_W + 1)'(1);
                end
                // hold freezes the read pipeline so the stalled RAM word is folded exactly once
                if (!i_hold) r_rd_valid <= w_issue;
                r_crc <= w_crc_next;
                if (r_state == S_DRAIN && !i_hold) r_crc_out <= w_crc_next;
            end
        end
    end

    assign o_busy          = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign o_done          = (r_state == S_DONE) && !i_abort;
    assign o_err           = r_err;
    assign o_crc_out       = r_crc_out;
    assign o_sp_address    = r_addr;
    assign o_sp_chipselect = w_issue;
    assign o_sp_write      = 1'b0;
    assign o_sp_byteenable = 4'hF;
    assign o_sp_clken      = ~i_hold;

endmodule

// File: tb/tb_fprint_scratchpad_crc_scanner.sv
// tb/tb_fprint_scratchpad_crc_scanner.sv - scoreboard bench for the scratchpad CRC scanner
module tb_fprint_scratchpad_crc_scanner;

    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              hold = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done, err;
    logic [31:0]       crc_out;
    logic [ADDR_W-1:0] sp_address;
    logic              sp_chipselect, sp_write, sp_clken;
    logic [3:0]        sp_byteenable;
    logic [31:0]       sp_readdata = '0;

    logic [31:0]       mem [0:DEPTH-1];

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [31:0]       exp_crc_q  [$];

    always #5 clk = ~clk;

    fprint_scratchpad_crc_scanner dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_start         (start),
        .i_base_addr     (base_addr),
        .i_word_count    (word_count),
        .i_hold          (hold),
        .i_abort         (abort),
        .o_busy          (busy),
        .o_done          (done),
        .o_err           (err),
        .o_crc_out       (crc_out),
        .o_sp_address    (sp_address),
        .o_sp_chipselect (sp_chipselect),
        .o_sp_write      (sp_write),
        .o_sp_byteenable (sp_byteenable),
        .o_sp_clken      (sp_clken),
        .i_sp_readdata   (sp_readdata)
    );

    // synchronous-read RAM whose output register only advances while clken is high
    always @(posedge clk) if (sp_clken) sp_readdata <= mem[sp_address];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_crc(input logic [ADDR_W-1:0] base, input int count);
        logic [31:0] c;
        logic [31:0] d;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < count; k++) begin
            d = mem[(int'(base) + k) % DEPTH];
            for (int b = 31; b >= 0; b--) begin
                fb = c[31] ^ d[b];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (sp_chipselect) begin
                n_acc++;
                if (exp_addr_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL addr_unexpected observed=%0d required=no access", sp_address);
                end else begin
                    chk("sp_address", 64'(sp_address), 64'(exp_addr_q.pop_front()));
                end
            end
            if (done) begin
                if (exp_crc_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL done_unexpected observed=done required=no done");
                end else begin
                    chk("crc_out", 64'(crc_out), 64'(exp_crc_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c,
                        input bit rand_hold, input bit with_abort, output int lat);
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        abort      = with_abort;
        if (c >= 1 && c <= DEPTH)
            for (int k = 0; k < int'(c); k++) exp_addr_q.push_back(ADDR_W'((int'(b) + k) % DEPTH));
        exp_crc_q.push_back(model_crc(b, (c > DEPTH) ? 0 : int'(c)));
        lat = -1;
        for (int k = 1; k <= 9000; k++) begin
            tick();
            start = 1'b0;
            abort = 1'b0;
            hold  = rand_hold ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        hold = 1'b0;
        if (lat < 0) begin
            total++;
            bad++;
            $error("FAIL done_timeout observed=no done required=done within 9000 cycles");
        end
        tick();
    endtask

    initial begin
        int lat;
        int acc0;
        logic [31:0] crc_ref;
        logic [31:0] prev;

        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_crc", 64'(crc_out), 64'(0));
        chk("rst_addr", 64'(sp_address), 64'(0));
        chk("rst_cs", 64'(sp_chipselect), 64'(0));
        chk("const_write", 64'(sp_write), 64'(0));
        chk("const_be", 64'(sp_byteenable), 64'hF);
        chk("clken", 64'(sp_clken), 64'(1));

        acc0 = n_acc;
        scan(0, 0, 0, 0, lat);
        chk("zero_lat", 64'(lat), 64'(1));
        chk("zero_crc", 64'(crc_out), 64'hFFFFFFFF);
        chk("zero_err", 64'(err), 64'(0));
        chk("zero_acc", 64'(n_acc - acc0), 64'(0));

        mem[5] = 32'hFFFFFFFF;
        acc0 = n_acc;
        scan(5, 1, 0, 0, lat);
        chk("one_lat", 64'(lat), 64'(3));
        chk("one_crc", 64'(crc_out), 64'(0));
        chk("one_acc", 64'(n_acc - acc0), 64'(1));

        scan(4094, 4, 0, 0, lat);
        chk("wrap_lat", 64'(lat), 64'(6));
        chk("wrap_left", 64'(exp_addr_q.size()), 64'(0));

        scan(700, 16, 0, 0, lat);
        chk("u16_lat", 64'(lat), 64'(18));
        crc_ref = crc_out;
        acc0 = n_acc;
        scan(700, 16, 1, 0, lat);
        chk("hold_crc", 64'(crc_out), 64'(crc_ref));
        chk("hold_acc", 64'(n_acc - acc0), 64'(16));

        scan(1000, 3, 0, 1, lat);
        chk("start_abort_lat", 64'(lat), 64'(5));

        prev = crc_out;
        start = 1'b1;
        base_addr = 200;
        word_count = 100;
        for (int k = 0; k < 3; k++) exp_addr_q.push_back(ADDR_W'(200 + k));
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_crc", 64'(crc_out), 64'(prev));
        for (int k = 0; k < 5; k++) tick();
        chk("abort_crc_held", 64'(crc_out), 64'(prev));
        chk("abort_left", 64'(exp_addr_q.size()), 64'(0));

        scan(3000, 5, 0, 0, lat);
        chk("post_abort_lat", 64'(lat), 64'(7));

        acc0 = n_acc;
        scan(100, 4096, 0, 0, lat);
        chk("full_lat", 64'(lat), 64'(4098));
        chk("full_acc", 64'(n_acc - acc0), 64'(4096));

        acc0 = n_acc;
        scan(0, 4097, 0, 0, lat);
        chk("err_lat", 64'(lat), 64'(1));
        chk("err_flag", 64'(err), 64'(1));
        chk("err_crc", 64'(crc_out), 64'hFFFFFFFF);
        chk("err_acc", 64'(n_acc - acc0), 64'(0));
        tick();
        chk("err_sticky", 64'(err), 64'(1));
        scan(9, 2, 0, 0, lat);
        chk("err_clear", 64'(err), 64'(0));

        start = 1'b1;
        base_addr = 0;
        word_count = 50;
        for (int k = 0; k < 50; k++) exp_addr_q.push_back(ADDR_W'(k));
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_cs", 64'(sp_chipselect), 64'(0));
        chk("mid_rst_addr", 64'(sp_address), 64'(0));
        chk("mid_rst_crc", 64'(crc_out), 64'(0));
        exp_addr_q.delete();
        exp_crc_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        scan(42, 7, 1, 0, lat);
        chk("post_rst_left", 64'(exp_addr_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
